// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA raster timing generator: timing presets,
// sync polarity constants and the delayed control bundle type.
package vga_timing_gen_pkg;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_HS_POL   = SYNC_ACTIVE_LOW;
    localparam bit VGA640_VS_POL   = SYNC_ACTIVE_LOW;

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 56;
    localparam int SVGA800_H_SYNC   = 120;
    localparam int SVGA800_H_BP     = 64;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 37;
    localparam int SVGA800_V_SYNC   = 6;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_HS_POL   = SYNC_ACTIVE_HIGH;
    localparam bit SVGA800_VS_POL   = SYNC_ACTIVE_HIGH;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic int cnt_width(input int h_total, input int v_total);
        return $clog2((h_total > v_total) ? h_total : v_total);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with asynchronous active-low reset;
// a depth of zero degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d = stage_q;
                if (ce) begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: walks the raster, requests pixels ahead of
// time and re-aligns sync/enable with the colour returned by the source.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL,
    parameter int COLOR_W  = 3,
    parameter int COORD_W  = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    output logic [COORD_W-1:0] req_x,
    output logic [COORD_W-1:0] req_y,
    output logic               req_valid,
    output logic               frame_start,
    output logic               line_start,
    input  logic [COLOR_W-1:0] px_r,
    input  logic [COLOR_W-1:0] px_g,
    input  logic [COLOR_W-1:0] px_b,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W   = cnt_width(H_TOTAL, V_TOTAL);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0};

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign req_x     = COORD_W'(h_cnt_q);
    assign req_y     = COORD_W'(v_cnt_q);
    assign req_valid = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);

    // Counters sit at (0,0) throughout reset; gating with rst_n keeps the
    // pulses quiet until the first tick after release.
    assign line_start  = rst_n && pix_ce && (h_cnt_q == '0);
    assign frame_start = line_start && (v_cnt_q == '0);

    sync_t sync_raw;
    sync_t sync_dly;

    always_comb begin
        sync_raw.de = req_valid;
        sync_raw.hs = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? HS_POL : !HS_POL;
        sync_raw.vs = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? VS_POL : !VS_POL;
    end

    vga_delay_line #(
        .WIDTH     ($bits(sync_t)),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (pix_ce),
        .din   (sync_raw),
        .dout  (sync_dly)
    );

    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               de_q, de_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;

    always_comb begin
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (pix_ce) begin
            hs_d = sync_dly.hs;
            vs_d = sync_dly.vs;
            de_d = sync_dly.de;
            r_d  = sync_dly.de ? px_r : '0;
            g_d  = sync_dly.de ? px_g : '0;
            b_d  = sync_dly.de ? px_b : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= !HS_POL;
            vs_q <= !VS_POL;
            de_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign hs = hs_q;
    assign vs = vs_q;
    assign de = de_q;
    assign r  = r_q;
    assign g  = g_q;
    assign b  = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small 15x8 raster with a 2-tick pixel
// source, plus a default-size instance with positive sync polarity.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HT = 15;
    localparam int VA = 4, VF = 1, VS = 2, VT = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        pix_ce = 1'b0;
    logic [15:0] req_x, req_y;
    logic        req_valid, frame_start, line_start;
    logic [2:0]  px_r, px_g, px_b;
    logic        hs, vs, de;
    logic [2:0]  r, g, b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .COLOR_W(3), .COORD_W(16), .PIPE_LAT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
        .frame_start(frame_start), .line_start(line_start),
        .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b)
    );

    // Pixel source: returns (req_x, req_y) two ticks after the request
    logic [2:0] p1_x, p2_x, p1_y, p2_y;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_x <= '0; p2_x <= '0; p1_y <= '0; p2_y <= '0;
        end else if (pix_ce) begin
            p1_x <= req_x[2:0]; p2_x <= p1_x;
            p1_y <= req_y[2:0]; p2_y <= p1_y;
        end
    end
    assign px_r = p2_x;
    assign px_g = p2_y;
    assign px_b = 3'd5;

    logic        rst2_n = 1'b0;
    logic        ce2    = 1'b0;
    logic [2:0]  zero3  = 3'd0;
    logic [15:0] req_x2, req_y2;
    logic        req_valid2, frame_start2, line_start2;
    logic        hs2, vs2, de2;
    logic [2:0]  r2, g2, b2;

    vga_timing_gen #(
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_big (
        .clk(clk), .rst_n(rst2_n), .pix_ce(ce2),
        .req_x(req_x2), .req_y(req_y2), .req_valid(req_valid2),
        .frame_start(frame_start2), .line_start(line_start2),
        .px_r(zero3), .px_g(zero3), .px_b(zero3),
        .hs(hs2), .vs(vs2), .de(de2), .r(r2), .g(g2), .b(b2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    int n, clk_cnt, last_fs, prev_fs, first_de, first_hs;
    int de_cnt, hs_lo, vs_lo;

    function automatic logic [31:0] exp_out(input int nn);
        logic hs_e, vs_e, de_e;
        logic [2:0] r_e, g_e, b_e;
        int c, h, v;
        hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0;
        r_e = '0; g_e = '0; b_e = '0;
        if (nn >= LAT) begin
            c = nn - LAT;
            h = c % HT;
            v = (c / HT) % VT;
            de_e = (h < HA) && (v < VA);
            hs_e = !((h >= HA + HF) && (h < HA + HF + HS));
            vs_e = !((v >= VA + VF) && (v < VA + VF + VS));
            if (de_e) begin
                r_e = 3'(h);
                g_e = 3'(v);
                b_e = 3'd5;
            end
        end
        return {20'd0, hs_e, vs_e, de_e, r_e, g_e, b_e};
    endfunction

    function automatic logic [31:0] exp_req(input int nn, input logic ce, input logic rst_ok);
        int h, v;
        logic ls_e, fs_e, rv_e;
        h = nn % HT;
        v = (nn / HT) % VT;
        ls_e = rst_ok && ce && (h == 0);
        fs_e = ls_e && (v == 0);
        rv_e = (h < HA) && (v < VA);
        return {13'd0, fs_e, ls_e, rv_e, 8'(h), 8'(v)};
    endfunction

    function automatic logic [31:0] obs_out();
        return {20'd0, hs, vs, de, r, g, b};
    endfunction

    function automatic logic [31:0] obs_req();
        return {13'd0, frame_start, line_start, req_valid, req_x[7:0], req_y[7:0]};
    endfunction

    // Holds reset for 3 clocks, checks the reset state, releases just after an edge.
    task automatic do_reset();
        pix_ce = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out", obs_out(), 32'hC00);
        check_val("rst_req", obs_req(), exp_req(0, 1'b1, 1'b0));
        rst_n = 1'b1;
        n = 0; clk_cnt = 0; last_fs = -1; prev_fs = -1;
        first_de = -1; first_hs = -1;
        de_cnt = 0; hs_lo = 0; vs_lo = 0;
    endtask

    task automatic cyc(input logic ce, input string tag);
        pix_ce = ce;
        @(negedge clk);
        check_val({tag, "_req"}, obs_req(), exp_req(n, ce, 1'b1));
        check_val({tag, "_out"}, obs_out(), exp_out(n));
        if (ce && n >= LAT && n < LAT + 240) begin
            if (de)  de_cnt++;
            if (!hs) hs_lo++;
            if (!vs) vs_lo++;
        end
        if (frame_start) begin
            prev_fs = last_fs;
            last_fs = clk_cnt;
        end
        if (de && first_de < 0)  first_de = n;
        if (!hs && first_hs < 0) first_hs = n;
        @(posedge clk);
        #1;
        clk_cnt++;
        if (ce) n++;
    endtask

    initial begin
        int hs2_hi, first_hs2;
        logic [31:0] e2;
        int c2, h2;

        // Reset release and two free-running frames
        do_reset();
        repeat (243) cyc(1'b1, "run");
        check_val("first_de_tick", 32'(first_de), 32'd3);
        check_val("first_hs_low_tick", 32'(first_hs), 32'd13);
        check_val("de_ticks_2fr", 32'(de_cnt), 32'd64);
        check_val("hs_low_2fr", 32'(hs_lo), 32'd48);
        check_val("vs_low_2fr", 32'(vs_lo), 32'd60);
        check_val("frame_period", 32'(last_fs - prev_fs), 32'd120);

        // Pixel enable every second clock
        do_reset();
        repeat (243) begin
            cyc(1'b1, "ce_half");
            cyc(1'b0, "ce_hold");
        end
        check_val("frame_period_ce2", 32'(last_fs - prev_fs), 32'd240);
        check_val("de_ticks_ce2", 32'(de_cnt), 32'd64);

        // Reset asserted mid-frame at line 2 column 5
        do_reset();
        repeat (35) cyc(1'b1, "pre_rst");
        check_val("pre_rst_out", obs_out(), exp_out(35));
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out", obs_out(), 32'hC00);
        check_val("mid_rst_req", obs_req(), exp_req(0, 1'b1, 1'b0));
        repeat (3) begin
            @(negedge clk);
            check_val("mid_rst_hold", obs_out(), 32'hC00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0; clk_cnt = 0; last_fs = -1; prev_fs = -1;
        first_de = -1; first_hs = -1;
        de_cnt = 0; hs_lo = 0; vs_lo = 0;
        repeat (243) cyc(1'b1, "post_rst");
        check_val("post_rst_first_de", 32'(first_de), 32'd3);
        check_val("post_rst_hs_low", 32'(hs_lo), 32'd48);
        check_val("post_rst_vs_low", 32'(vs_lo), 32'd60);

        // Default 800x525 raster with active-high syncs, first two lines
        ce2 = 1'b1;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        hs2_hi = 0;
        first_hs2 = -1;
        for (int i = 0; i < 1605; i++) begin
            @(negedge clk);
            e2 = '0;
            e2[5] = ((i % 800) == 0);
            e2[4] = (i == 0);
            e2[3] = ((i % 800) < 640);
            if (i >= LAT) begin
                c2 = i - LAT;
                h2 = c2 % 800;
                e2[2] = (h2 >= 656) && (h2 < 752);
                e2[0] = (h2 < 640);
            end
            check_val("big_ctl", {26'd0, line_start2, frame_start2, req_valid2, hs2, vs2, de2}, e2);
            check_val("big_req_x", {16'd0, req_x2}, 32'(i % 800));
            if (hs2 && i >= LAT && i < LAT + 800) hs2_hi++;
            if (hs2 && first_hs2 < 0) first_hs2 = i;
            @(posedge clk);
            #1;
        end
        check_val("big_hs_width", 32'(hs2_hi), 32'd96);
        check_val("big_first_hs", 32'(first_hs2), 32'd659);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
